// File: rtl/prm_edge_scan_ctrl.sv
// PRM edge-scan sequencer: walks the edge-checker bank for one latched obstacle code
// and streams blocked edge indices through a small credit-limited FIFO.
module prm_edge_scan_ctrl #(
    parameter int N_EDGE  = 256,
    parameter int IDX_W   = 8,
    parameter int OBS_W   = 15,
    parameter int CHK_LAT = 1,
    parameter int FIFO_D  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OBS_W-1:0] obs_vec,
    output logic [OBS_W-1:0] chk_obs,
    output logic [IDX_W-1:0] chk_idx,
    output logic             chk_issue,
    input  logic             chk_mask,
    output logic             edge_valid,
    output logic [IDX_W-1:0] edge_idx,
    input  logic             edge_ready,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   blocked_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int PTR_W = $clog2(FIFO_D);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EDGE - 1);

    logic [1:0]         state;
    logic [CHK_LAT-1:0] pipe_v;
    logic [CHK_LAT-1:0] pipe_v_nxt;
    logic [IDX_W-1:0]   pipe_idx [CHK_LAT];
    logic [IDX_W-1:0]   fifo_mem [FIFO_D];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic [PTR_W:0]     fifo_cnt_nxt;
    logic [15:0]        occupancy;
    logic               flush;
    logic               push;
    logic               pop;

    // Every issued query reserves a FIFO slot until its result lands, so the FIFO cannot overflow.
    always_comb begin
        occupancy = 16'(fifo_cnt);
        for (int i = 0; i < CHK_LAT; i++) begin
            occupancy = occupancy + 16'(pipe_v[i]);
        end
    end

    assign chk_issue    = (state == ST_SCAN) && (occupancy < 16'(FIFO_D));
    assign flush        = abort && (state != ST_IDLE);
    assign push         = pipe_v[CHK_LAT-1] && chk_mask && !flush;
    assign pop          = edge_valid && edge_ready;
    assign pipe_v_nxt   = CHK_LAT'({pipe_v, chk_issue});
    assign fifo_cnt_nxt = fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    assign edge_valid = (fifo_cnt != '0);
    assign edge_idx   = edge_valid ? fifo_mem[rd_ptr] : '0;
    assign busy       = (state == ST_SCAN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            chk_obs     <= '0;
            chk_idx     <= '0;
            blocked_cnt <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            if (push) begin
                blocked_cnt <= blocked_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        chk_obs     <= obs_vec;
                        chk_idx     <= '0;
                        blocked_cnt <= '0;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (chk_issue) begin
                        if (chk_idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            chk_idx <= chk_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once nothing will be in flight or buffered next cycle.
                    if ((pipe_v_nxt == '0) && (fifo_cnt_nxt == '0)) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < CHK_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
        end else if (flush) begin
            pipe_v   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            pipe_v      <= pipe_v_nxt;
            pipe_idx[0] <= chk_idx;
            for (int i = 1; i < CHK_LAT; i++) begin
                pipe_idx[i] <= pipe_idx[i-1];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pipe_idx[CHK_LAT-1];
        end
    end

endmodule

// File: doc/prm_edge_scan_ctrl.md
Name: prm_edge_scan_ctrl

Overview:
Sequencer for the bank of PRM edge-obstacle checkers (one combinational checker per roadmap edge, 15-bit obstacle code in, edge_mask out).
- On start, latches one obstacle code and presents it to the bank.
- Steps the bank mux through every edge index and collects each edge_mask result.
- Streams the indices of blocked edges to the roadmap-update logic over a valid/ready interface.
- Sits between the obstacle encoder and the graph/edge-validity memory.

Parameters:
N_EDGE, 256, number of edge checkers in the bank (1..2^IDX_W).
IDX_W, 8, edge index width.
OBS_W, 15, obstacle code width (checker inputs A..O; bit 0 = A).
CHK_LAT, 1, cycles from chk_idx/chk_issue to valid chk_mask (1..3).
FIFO_D, 4, depth of blocked-index output FIFO (power of 2, >= 2).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a scan; sampled only in IDLE.
abort  in  1  synchronous flush back to IDLE.
obs_vec  in  OBS_W  obstacle code; latched on accepted start.
chk_obs  out  OBS_W  latched obstacle code driven to the checker bank.
chk_idx  out  IDX_W  edge index selecting the bank mux.
chk_issue  out  1  chk_idx is a live query this cycle.
chk_mask  in  1  bank result for the query issued CHK_LAT cycles earlier.
edge_valid  out  1  blocked edge index available.
edge_idx  out  IDX_W  blocked edge index (FIFO head).
edge_ready  in  1  consumer accepts edge_idx.
busy  out  1  scan in progress.
done  out  1  one-cycle pulse at scan completion.
blocked_cnt  out  IDX_W+1  blocked edges in current/last scan.

Behaviour:
- Reset (rst_n=0, async): state IDLE. All outputs 0 (busy, done, chk_obs, chk_idx, chk_issue, edge_valid, edge_idx, blocked_cnt). FIFO empty; in-flight pipeline cleared.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1: chk_obs<=obs_vec, chk_idx<=0, blocked_cnt<=0, go to SCAN, busy=1 from next cycle.
  - blocked_cnt holds the previous scan's value until then.
- SCAN, issue rule: issue when fifo_count + inflight < FIFO_D.
  - inflight = issued queries whose result is not yet returned.
  - On issue: chk_issue=1, chk_idx is the current index; chk_idx increments after issue.
  - On stall: chk_issue=0, chk_idx held.
- Result capture: a CHK_LAT-deep valid/index shift pipe tracks each issued query.
  - When the pipe output is valid and chk_mask=1: push its index into the FIFO; blocked_cnt+1.
  - chk_mask is ignored when the pipe output is not valid.
- After issuing index N_EDGE-1: go to DRAIN; chk_issue=0; chk_idx holds N_EDGE-1.
- DRAIN: wait until inflight=0 and FIFO empty, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- Output FIFO:
  - edge_valid = FIFO not empty.
  - edge_idx stable while edge_valid=1 and edge_ready=0.
  - Pop on edge_valid&edge_ready.
  - Indices are emitted in strictly ascending order.
  - Push and pop in the same cycle are legal at any occupancy; the issue rule guarantees no overflow and no result is ever dropped.
- start while not IDLE: ignored. obs_vec changes after the latch: no effect on chk_obs.
- abort (any state except IDLE): next cycle IDLE, FIFO and pipe flushed, edge_valid=0, no done pulse, blocked_cnt frozen. abort has priority over start in the same cycle.
- N_EDGE=1: one issue, then DRAIN.
- The index counter never wraps: the last-index compare uses N_EDGE-1.
- Timing, no stalls: start sampled at cycle 0; issues at cycles 1..N_EDGE; last result at N_EDGE+CHK_LAT; done at the first cycle after both inflight=0 and FIFO empty.

Test Plan:
1. N_EDGE=8, CHK_LAT=1, bank model blocks idx {2,5}, edge_ready=1, obs_vec=15'h1A3 -> chk_obs=15'h1A3; edge_idx 2 then 5, one cycle each; blocked_cnt=2; single done pulse.
2. N_EDGE=8, all edges blocked, edge_ready=0 for 20 cycles -> issue stalls with 4 entries buffered and chk_idx=4. Then ready=1 -> edge_idx 0..7 in order, no loss/duplication, blocked_cnt=8.
3. N_EDGE=8, CHK_LAT=1, nothing blocked -> edge_valid never asserts; done at cycle 10 after start; blocked_cnt=0.
4. start pulsed and obs_vec changed mid-scan -> ignored; chk_obs unchanged; exactly one done.
5. abort at the issue of idx 3 with FIFO non-empty -> IDLE next cycle, edge_valid=0, no done. rst_n low mid-scan -> all outputs 0 immediately (async).
6. CHK_LAT=3, blocked {0,7}, random edge_ready -> edge stream 0,7, correct index/result alignment, no overflow.
